module_alu_hs: RTL and testbench

//  Parametrised successor of the Mini-CPU ALU. Same 3-bit opcode set, generic datapath width and

---
 rtl/module_alu_hs.sv | 192 +++++++++++++++++++
 tb/tb_module_alu_hs.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/module_alu_hs.sv
// Mini-CPU ALU with valid/ready handshakes on both sides, an optional iterative
// shift-add multiplier and registered zero/negative/overflow flags.
module module_alu_hs #(
  parameter int WIDTH         = 16,
  parameter int IMM_WIDTH     = 6,
  parameter int MUL_ITERATIVE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           opcode,
  input  logic [WIDTH-1:0]     valor1,
  input  logic [WIDTH-1:0]     valor2,
  input  logic                 sinal_imm,
  input  logic [IMM_WIDTH-1:0] imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     saida,
  output logic                 flag_zero,
  output logic                 flag_neg,
  output logic                 flag_ovf,
  output logic                 busy
);

  localparam int CW = (IMM_WIDTH > 1) ? $clog2(IMM_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(IMM_WIDTH - 1);
  localparam bit ITER = (MUL_ITERATIVE != 0);

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_ADD     = 3'b001;
  localparam logic [2:0] OP_ADDI    = 3'b010;
  localparam logic [2:0] OP_SUB     = 3'b011;
  localparam logic [2:0] OP_SUBI    = 3'b100;
  localparam logic [2:0] OP_MUL     = 3'b101;
  localparam logic [2:0] OP_CLEAR   = 3'b110;
  localparam logic [2:0] OP_DISPLAY = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state;
  logic [2:0]             lat_op;
  logic [WIDTH-1:0]       lat_v1;
  logic [WIDTH-1:0]       lat_v2;
  logic                   lat_sgn;
  logic [IMM_WIDTH-1:0]   lat_imm;
  logic [2*WIDTH-1:0]     acc;
  logic [2*WIDTH-1:0]     mcand;
  logic [IMM_WIDTH-1:0]   mplier;
  logic [CW-1:0]          cnt;

  logic                   accept;
  logic [WIDTH-1:0]       imm_ext;
  logic [WIDTH-1:0]       simm;
  logic [2*WIDTH-1:0]     prod_full;
  logic [WIDTH-1:0]       alu_res;
  logic                   alu_ovf;
  logic [2*WIDTH-1:0]     acc_step;
  logic [2*WIDTH-1:0]     mul_final;

  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // A 2*WIDTH product fits in WIDTH signed bits only if its top WIDTH+1 bits agree.
  function automatic logic prod_ovf(input logic [2*WIDTH-1:0] p);
    return !((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1]));
  endfunction

  assign accept   = in_valid && in_ready;
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign busy     = (state == EXEC) || (state == MUL);

  // Single-cycle datapath on the latched operands.
  always_comb begin
    imm_ext   = {{(WIDTH-IMM_WIDTH){1'b0}}, lat_imm};
    simm      = lat_sgn ? (-imm_ext) : imm_ext;
    prod_full = {{WIDTH{lat_v1[WIDTH-1]}}, lat_v1} * {{WIDTH{simm[WIDTH-1]}}, simm};
    alu_res   = {WIDTH{1'b0}};
    alu_ovf   = 1'b0;
    case (lat_op)
      OP_LOAD:    alu_res = simm;
      OP_ADD: begin
        alu_res = lat_v1 + lat_v2;
        alu_ovf = add_ovf(lat_v1[WIDTH-1], lat_v2[WIDTH-1], alu_res[WIDTH-1]);
      end
      OP_ADDI: begin
        alu_res = lat_v1 + simm;
        alu_ovf = add_ovf(lat_v1[WIDTH-1], simm[WIDTH-1], alu_res[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = lat_v1 - lat_v2;
        alu_ovf = add_ovf(lat_v1[WIDTH-1], !lat_v2[WIDTH-1], alu_res[WIDTH-1]);
      end
      OP_SUBI: begin
        alu_res = lat_v1 - simm;
        alu_ovf = add_ovf(lat_v1[WIDTH-1], !simm[WIDTH-1], alu_res[WIDTH-1]);
      end
      OP_MUL: begin
        alu_res = prod_full[WIDTH-1:0];
        alu_ovf = prod_ovf(prod_full);
      end
      OP_CLEAR:   alu_res = {WIDTH{1'b0}};
      OP_DISPLAY: alu_res = lat_v1;
      default: begin
        alu_res = {WIDTH{1'b0}};
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Shift-add step; the sign of the immediate is applied once at the end.
  always_comb begin
    acc_step  = acc + (mplier[0] ? mcand : {(2*WIDTH){1'b0}});
    mul_final = lat_sgn ? (-acc_step) : acc_step;
  end

  // Handshake FSM, operand latches, multiplier state and registered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_op    <= 3'b000;
      lat_v1    <= {WIDTH{1'b0}};
      lat_v2    <= {WIDTH{1'b0}};
      lat_sgn   <= 1'b0;
      lat_imm   <= {IMM_WIDTH{1'b0}};
      acc       <= {(2*WIDTH){1'b0}};
      mcand     <= {(2*WIDTH){1'b0}};
      mplier    <= {IMM_WIDTH{1'b0}};
      cnt       <= {CW{1'b0}};
      out_valid <= 1'b0;
      saida     <= {WIDTH{1'b0}};
      flag_zero <= 1'b0;
      flag_neg  <= 1'b0;
      flag_ovf  <= 1'b0;
    end else if (accept) begin
      lat_op    <= opcode;
      lat_v1    <= valor1;
      lat_v2    <= valor2;
      lat_sgn   <= sinal_imm;
      lat_imm   <= imm;
      acc       <= {(2*WIDTH){1'b0}};
      mcand     <= {{WIDTH{valor1[WIDTH-1]}}, valor1};
      mplier    <= imm;
      cnt       <= {CW{1'b0}};
      out_valid <= 1'b0;
      state     <= ((opcode == OP_MUL) && ITER) ? MUL : EXEC;
    end else begin
      case (state)
        IDLE: state <= IDLE;
        EXEC: begin
          saida     <= alu_res;
          flag_zero <= (alu_res == {WIDTH{1'b0}});
          flag_neg  <= alu_res[WIDTH-1];
          flag_ovf  <= alu_ovf;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        MUL: begin
          if (cnt == LAST) begin
            saida     <= mul_final[WIDTH-1:0];
            flag_zero <= (mul_final[WIDTH-1:0] == {WIDTH{1'b0}});
            flag_neg  <= mul_final[WIDTH-1];
            flag_ovf  <= prod_ovf(mul_final);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc    <= acc_step;
            mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
            mplier <= mplier >> 1'b1;
            cnt    <= cnt + CW'(1'b1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_module_alu_hs.sv
// Randomized and directed bench for module_alu_hs against an integer-arithmetic reference model.
module tb_module_alu_hs;

  localparam int W  = 16;
  localparam int IW = 6;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    opcode;
  logic [W-1:0]  valor1;
  logic [W-1:0]  valor2;
  logic          sinal_imm;
  logic [IW-1:0] imm;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  saida;
  logic          flag_zero;
  logic          flag_neg;
  logic          flag_ovf;
  logic          busy;

  int vectors;
  int miscompares;

  module_alu_hs #(.WIDTH(W), .IMM_WIDTH(IW), .MUL_ITERATIVE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .valor1(valor1), .valor2(valor2),
    .sinal_imm(sinal_imm), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .saida(saida), .flag_zero(flag_zero),
    .flag_neg(flag_neg), .flag_ovf(flag_ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result as plain signed arithmetic, overflow as "outside the WIDTH-bit signed range".
  function automatic void ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic s,
                                    input logic [IW-1:0] im,
                                    output logic [W-1:0] r, output logic ovf);
    longint sa, sb, si, full;
    longint maxp, minn;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    si   = s ? -longint'(im) : longint'(im);
    maxp = (64'sd1 <<< (W - 1)) - 64'sd1;
    minn = -(64'sd1 <<< (W - 1));
    case (op)
      3'd0:    full = si;
      3'd1:    full = sa + sb;
      3'd2:    full = sa + si;
      3'd3:    full = sa - sb;
      3'd4:    full = sa - si;
      3'd5:    full = sa * si;
      3'd6:    full = 64'sd0;
      default: full = sa;
    endcase
    r   = full[W-1:0];
    ovf = (op >= 3'd1) && (op <= 3'd5) && ((full > maxp) || (full < minn));
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("%s_ov_after", tag), 32'(out_valid), 32'd0);
    check($sformatf("%s_rdy_after", tag), 32'(in_ready), 32'd1);
  endtask

  // Issue one op from IDLE, scramble the inputs after accept, then check latency and result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic s, input logic [IW-1:0] im,
                        input bit do_release);
    logic [W-1:0] er;
    logic         eo;
    int           lat;
    bit           busy_bad;
    ref_model(op, a, b, s, im, er, eo);
    check($sformatf("%s_in_ready", tag), 32'(in_ready), 32'd1);
    opcode = op; valor1 = a; valor2 = b; sinal_imm = s; imm = im;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    opcode = 3'($urandom); valor1 = W'($urandom); valor2 = W'($urandom);
    sinal_imm = 1'($urandom); imm = IW'($urandom);
    lat = 0;
    busy_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (!busy || in_ready) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s_latency", tag), 32'(lat), (op == 3'd5) ? 32'(IW) : 32'd1);
    check($sformatf("%s_busy", tag), 32'(busy_bad), 32'd0);
    check($sformatf("%s_saida", tag), 32'(saida), 32'(er));
    check($sformatf("%s_zero", tag), 32'(flag_zero), 32'(er == '0));
    check($sformatf("%s_neg", tag), 32'(flag_neg), 32'(er[W-1]));
    check($sformatf("%s_ovf", tag), 32'(flag_ovf), 32'(eo));
    check($sformatf("%s_busy_done", tag), 32'(busy), 32'd0);
    if (do_release) release_out(tag);
  endtask

  initial begin
    int  cyc;
    bit  stale;
    logic [2:0] rop;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; opcode = 3'd0;
    valor1 = '0; valor2 = '0; sinal_imm = 1'b0; imm = '0;
    repeat (2) @(negedge clk);
    check("rst_saida", 32'(saida), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", 32'({flag_zero, flag_neg, flag_ovf}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    run_op("t1_add", 3'd1, 16'h7FFF, 16'h0001, 1'b0, 6'd0, 1'b0);
    check("t1_saida_const", 32'(saida), 32'h8000);
    check("t1_flags_const", 32'({flag_zero, flag_neg, flag_ovf}), 32'b011);
    release_out("t1");

    run_op("t2_addi", 3'd2, 16'd10, 16'd0, 1'b1, 6'd3, 1'b0);
    check("t2_addi_const", 32'(saida), 32'd7);
    release_out("t2a");
    run_op("t2_subi", 3'd4, 16'd10, 16'd0, 1'b1, 6'd3, 1'b0);
    check("t2_subi_const", 32'(saida), 32'd13);
    release_out("t2b");
    run_op("t2_load", 3'd0, 16'd0, 16'd0, 1'b1, 6'd5, 1'b0);
    check("t2_load_const", 32'(saida), 32'hFFFB);
    release_out("t2c");

    run_op("t3_mul", 3'd5, 16'd1000, 16'd0, 1'b1, 6'd63, 1'b0);
    check("t3_saida_const", 32'(saida), 32'h09E8);
    check("t3_ovf_const", 32'(flag_ovf), 32'd1);
    release_out("t3");
    run_op("mul_imm0", 3'd5, 16'h1234, 16'd0, 1'b1, 6'd0, 1'b1);

    // Result held under backpressure, then a back-to-back CLEAR in the handshake edge.
    run_op("t4_add", 3'd1, 16'h7FFF, 16'h0001, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t4_hold_saida%0d", i), 32'(saida), 32'h8000);
      check($sformatf("t4_hold_flags%0d", i), 32'({out_valid, flag_zero, flag_neg, flag_ovf}), 32'b1011);
      check($sformatf("t4_hold_rdy%0d", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1; in_valid = 1'b1; opcode = 3'd6; valor1 = 16'h5555;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    check("t4_b2b_ov", 32'(out_valid), 32'd0);
    check("t4_b2b_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t4_clear_ov", 32'(out_valid), 32'd1);
    check("t4_clear_saida", 32'(saida), 32'd0);
    check("t4_clear_zero", 32'(flag_zero), 32'd1);
    release_out("t4");

    // Reset three cycles into a multiply.
    opcode = 3'd5; valor1 = 16'd1000; sinal_imm = 1'b1; imm = 6'd63; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_saida", 32'(saida), 32'd0);
    check("t5_ctl", 32'({out_valid, busy, flag_zero, flag_neg, flag_ovf}), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    stale = 1'b0;
    for (cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (out_valid || busy) stale = 1'b1;
    end
    check("t5_no_stale", 32'(stale), 32'd0);

    for (int n = 0; n < 60; n++) begin
      rop = 3'($urandom);
      run_op($sformatf("rnd%0d", n), rop, pick_operand(), pick_operand(),
             1'($urandom), IW'($urandom), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
